fb_port_arbiter: RTL and testbench

Shares the single frame-buffer BRAM port between the VGA scanout reader, a pixel-write queue fed by the draw engine, and a built-in frame-clear sequencer. It sits between the scanout path and the BRAM and drives the `buffer_*` port group. Scanout reads always win, so display timing is never disturbed. Writes drain in idle cycles: horizontal/vertical blanking and any other cycle with no read request.

---
 rtl/fb_pkg.sv | 31 +++
 rtl/latency.sv | 32 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/fb_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_fb_port_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants: frame geometry, queued write
// entry, grant encoding and clear-sequencer states.
package fb_pkg;

  localparam int unsigned FB_ADDR_BITS = 17;
  localparam int unsigned FB_BYTES     = 120000;
  localparam int unsigned FB_WORDS     = (FB_BYTES + 3) / 4;

  typedef struct packed {
    logic [FB_ADDR_BITS-1:0] addr;
    logic [7:0]              data;
  } fb_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_READ,
    GNT_CLEAR,
    GNT_WRITE
  } fb_gnt_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_BUSY
  } fb_clr_state_e;

  // Single-byte write enable for the lane selected by the low address bits.
  function automatic logic [3:0] lane_we(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/latency.sv
// Fixed-depth delay line with synchronous reset; DEPTH of 0 is a wire.
module latency #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift the input through DEPTH registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags. A pop in the same cycle frees a
// slot, so a push into a full FIFO is accepted when it pops together.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer BRAM port arbiter: scanout reads first, then the frame-clear
// sequencer, then the queued pixel writes. One access per cycle.
// Optional FB_ARB_STATS_EN adds committed-write and stall counters.
module fb_port_arbiter #(
  parameter int unsigned BUFFER_ADDR_BITS          = 17,
  parameter int unsigned FB_BYTES                  = 120000,
  parameter int unsigned FIFO_DEPTH_LOG2           = 2,
  parameter int unsigned FRAME_BUFFER_READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_valid,
  input  logic [BUFFER_ADDR_BITS-1:0] rd_addr,
  output logic [7:0]                  rd_byte,
  output logic                        rd_byte_valid,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [BUFFER_ADDR_BITS-1:0] wr_addr,
  input  logic [7:0]                  wr_data,
  input  logic                        clear_start,
  input  logic [7:0]                  clear_color,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic [31:0]                 buffer_addr,
  output logic [31:0]                 buffer_din,
  input  logic [31:0]                 buffer_dout,
  output logic                        buffer_en,
  output logic                        buffer_rst,
  output logic [3:0]                  buffer_we
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_writes,
  output logic [31:0]                 stat_stall_cycles
`endif
);

  import fb_pkg::*;

  localparam int unsigned     PTR_W     = BUFFER_ADDR_BITS - 2;
  localparam int unsigned     CLR_WORDS = (FB_BYTES + 3) / 4;
  localparam logic [PTR_W-1:0] CLR_LAST = PTR_W'(CLR_WORDS - 1);
  localparam int unsigned     WR_W      = $bits(fb_wr_t);

  fb_gnt_e          gnt;
  fb_clr_state_e    clr_state;
  fb_clr_state_e    clr_state_nxt;
  logic             clr_last_word;
  logic [PTR_W-1:0] clr_ptr;
  logic [7:0]       clr_colour;

  fb_wr_t           fifo_in;
  fb_wr_t           fifo_out;
  logic [WR_W-1:0]  fifo_out_bits;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  logic [2:0]       rd_pipe_out;

  assign buffer_rst = 1'b0;
  assign clear_busy = (clr_state == CLR_BUSY);

  // Per-cycle grant: read beats clear beats queued write; nothing in reset.
  always_comb begin
    gnt = GNT_NONE;
    if (rst)               gnt = GNT_NONE;
    else if (rd_valid)     gnt = GNT_READ;
    else if (clear_busy)   gnt = GNT_CLEAR;
    else if (!fifo_empty)  gnt = GNT_WRITE;
  end

  // Write queue: a pop in this cycle makes room for a push when full.
  assign fifo_pop      = (gnt == GNT_WRITE);
  assign wr_ready      = !rst && (!fifo_full || fifo_pop);
  assign fifo_push     = wr_valid && wr_ready;
  assign fifo_in.addr  = FB_ADDR_BITS'(wr_addr);
  assign fifo_in.data  = wr_data;
  assign fifo_out      = fb_wr_t'(fifo_out_bits);

  sync_fifo #(
    .WIDTH      (WR_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (fifo_out_bits),
    .empty     (fifo_empty)
  );

  // BRAM port drive from the current grant.
  always_comb begin
    buffer_addr = '0;
    buffer_din  = '0;
    buffer_we   = '0;
    buffer_en   = 1'b0;
    case (gnt)
      GNT_READ: begin
        buffer_en   = 1'b1;
        buffer_addr = 32'(rd_addr);
      end
      GNT_CLEAR: begin
        buffer_en   = 1'b1;
        buffer_we   = '1;
        buffer_addr = 32'({clr_ptr, 2'b00});
        buffer_din  = {4{clr_colour}};
      end
      GNT_WRITE: begin
        buffer_en   = 1'b1;
        buffer_we   = lane_we(fifo_out.addr[1:0]);
        buffer_addr = 32'(fifo_out.addr);
        buffer_din  = {4{fifo_out.data}};
      end
      default: ;
    endcase
  end

  // Clear sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) clr_state <= CLR_IDLE;
    else     clr_state <= clr_state_nxt;
  end

  // Clear sequencer next state; leaves CLR_BUSY once the last word is granted.
  always_comb begin
    clr_state_nxt = clr_state;
    clr_last_word = 1'b0;
    case (clr_state)
      CLR_IDLE: if (clear_start) clr_state_nxt = CLR_BUSY;
      CLR_BUSY: begin
        if (gnt == GNT_CLEAR && clr_ptr == CLR_LAST) begin
          clr_state_nxt = CLR_IDLE;
          clr_last_word = 1'b1;
        end
      end
      default: clr_state_nxt = CLR_IDLE;
    endcase
  end

  // Clear datapath: colour latch, word pointer and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr    <= '0;
      clr_colour <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= clr_last_word;
      if (clr_state == CLR_IDLE && clear_start) begin
        clr_ptr    <= '0;
        clr_colour <= clear_color;
      end else if (gnt == GNT_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  latency #(
    .WIDTH (3),
    .DEPTH (FRAME_BUFFER_READ_LATENCY)
  ) u_rd_lat (
    .clk  (clk),
    .rst  (rst),
    .din  ({gnt == GNT_READ, rd_addr[1:0]}),
    .dout (rd_pipe_out)
  );

  assign rd_byte_valid = rd_pipe_out[2];
  assign rd_byte       = rd_pipe_out[2] ? buffer_dout[{rd_pipe_out[1:0], 3'b000} +: 8] : '0;

`ifdef FB_ARB_STATS_EN
  // Saturating counters of committed writes and denied non-empty cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_writes       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (gnt == GNT_WRITE && stat_writes != '1)
        stat_writes <= stat_writes + 32'd1;
      if (!fifo_empty && gnt != GNT_WRITE && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: reset, idle write, read priority,
// queue full, full-frame clear, clear under read traffic with reset abort,
// and read data return.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid;
  logic [16:0] rd_addr;
  logic [7:0]  rd_byte;
  logic        rd_byte_valid;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        clear_start;
  logic [7:0]  clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic [31:0] buffer_addr;
  logic [31:0] buffer_din;
  logic [31:0] buffer_dout;
  logic        buffer_en;
  logic        buffer_rst;
  logic [3:0]  buffer_we;
`ifdef FB_ARB_STATS_EN
  logic [31:0] stat_writes;
  logic [31:0] stat_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(
    .BUFFER_ADDR_BITS          (17),
    .FB_BYTES                  (120000),
    .FIFO_DEPTH_LOG2           (2),
    .FRAME_BUFFER_READ_LATENCY (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rd_valid          (rd_valid),
    .rd_addr           (rd_addr),
    .rd_byte           (rd_byte),
    .rd_byte_valid     (rd_byte_valid),
    .wr_valid          (wr_valid),
    .wr_ready          (wr_ready),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .clear_start       (clear_start),
    .clear_color       (clear_color),
    .clear_busy        (clear_busy),
    .clear_done        (clear_done),
    .buffer_addr       (buffer_addr),
    .buffer_din        (buffer_din),
    .buffer_dout       (buffer_dout),
    .buffer_en         (buffer_en),
    .buffer_rst        (buffer_rst),
    .buffer_we         (buffer_we)
`ifdef FB_ARB_STATS_EN
    ,
    .stat_writes       (stat_writes),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (buffer_we !== 4'h0) begin
        failures++; $display("FAIL reset_we[%0d]: got %h expected 0", i, buffer_we);
      end
      checks++;
      if (wr_ready !== 1'b0) begin
        failures++; $display("FAIL reset_wr_ready[%0d]: got %b expected 0", i, wr_ready);
      end
      checks++;
      if (buffer_en !== 1'b0) begin
        failures++; $display("FAIL reset_en[%0d]: got %b expected 0", i, buffer_en);
      end
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_wr_ready: got %b expected 1", wr_ready);
    end
    checks++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
      failures++; $display("FAIL post_reset_clear: got busy=%b done=%b expected 0/0", clear_busy, clear_done);
    end
    checks++;
    if (rd_byte_valid !== 1'b0 || rd_byte !== 8'h00) begin
      failures++; $display("FAIL post_reset_rd: got valid=%b byte=%h expected 0/00", rd_byte_valid, rd_byte);
    end
    checks++;
    if (buffer_en !== 1'b0 || buffer_we !== 4'h0 || buffer_rst !== 1'b0) begin
      failures++; $display("FAIL post_reset_buffer: got en=%b we=%h rst=%b expected 0/0/0", buffer_en, buffer_we, buffer_rst);
    end
  endtask

  task automatic test_idle_write();
    tick();
    wr_valid = 1'b1; wr_addr = 17'd5; wr_data = 8'hA5;
    #1;
    checks++;
    if (buffer_en !== 1'b0) begin
      failures++; $display("FAIL idle_write_pre_en: got %b expected 0", buffer_en);
    end
    tick();
    wr_valid = 1'b0;
    #1;
    checks++;
    if (buffer_addr !== 32'd5 || buffer_we !== 4'b0010 || buffer_din !== 32'hA5A5A5A5 || buffer_en !== 1'b1) begin
      failures++;
      $display("FAIL idle_write: got addr=%h we=%b din=%h en=%b expected 5/0010/A5A5A5A5/1", buffer_addr, buffer_we, buffer_din, buffer_en);
    end
    tick();
    #1;
    checks++;
    if (buffer_en !== 1'b0) begin
      failures++; $display("FAIL idle_write_drained: got en=%b expected 0", buffer_en);
    end
  endtask

  task automatic test_read_priority();
    logic [16:0] a [3];
    logic [7:0]  d [3];
    logic [3:0]  w [3];
    a[0] = 17'h100; d[0] = 8'h11; w[0] = 4'b0001;
    a[1] = 17'h203; d[1] = 8'h22; w[1] = 4'b1000;
    a[2] = 17'h302; d[2] = 8'h33; w[2] = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      rd_valid = 1'b1;
      rd_addr  = 17'(c * 4);
      wr_valid = (c < 3);
      if (c < 3) begin
        wr_addr = a[c]; wr_data = d[c];
      end
      #1;
      checks++;
      if (buffer_we !== 4'h0 || buffer_en !== 1'b1 || buffer_addr !== 32'(c * 4)) begin
        failures++;
        $display("FAIL read_priority_cycle%0d: got we=%h en=%b addr=%h expected 0/1/%h", c, buffer_we, buffer_en, buffer_addr, c * 4);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      rd_valid = 1'b0; wr_valid = 1'b0;
      #1;
      checks++;
      if (buffer_addr !== 32'(a[k]) || buffer_we !== w[k] || buffer_din !== {4{d[k]}}) begin
        failures++;
        $display("FAIL read_priority_commit%0d: got addr=%h we=%b din=%h expected %h/%b/%h", k, buffer_addr, buffer_we, buffer_din, a[k], w[k], {4{d[k]}});
      end
    end
    tick();
    #1;
    checks++;
    if (buffer_en !== 1'b0) begin
      failures++; $display("FAIL read_priority_drained: got en=%b expected 0", buffer_en);
    end
  endtask

  task automatic test_fifo_full();
    logic [16:0] a [5];
    logic [7:0]  d [5];
    logic [3:0]  w [5];
    int idx;
    for (int i = 0; i < 5; i++) begin
      a[i] = 17'(16 + i);
      d[i] = 8'(8'h50 + i);
      w[i] = 4'b0001 << ((16 + i) % 4);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      idx = (c < 4) ? c : 4;
      rd_valid = 1'b1; rd_addr = 17'd0;
      wr_valid = 1'b1; wr_addr = a[idx]; wr_data = d[idx];
      #1;
      checks++;
      if (wr_ready !== ((c < 4) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL fifo_full_ready_cycle%0d: got %b expected %b", c, wr_ready, (c < 4));
      end
    end
    tick();
    rd_valid = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++; $display("FAIL fifo_full_pop_ready: got %b expected 1", wr_ready);
    end
    checks++;
    if (buffer_addr !== 32'(a[0]) || buffer_we !== w[0] || buffer_din !== {4{d[0]}}) begin
      failures++;
      $display("FAIL fifo_full_commit0: got addr=%h we=%b din=%h expected %h/%b/%h", buffer_addr, buffer_we, buffer_din, a[0], w[0], {4{d[0]}});
    end
    for (int k = 1; k < 5; k++) begin
      tick();
      wr_valid = 1'b0;
      #1;
      checks++;
      if (buffer_addr !== 32'(a[k]) || buffer_we !== w[k] || buffer_din !== {4{d[k]}}) begin
        failures++;
        $display("FAIL fifo_full_commit%0d: got addr=%h we=%b din=%h expected %h/%b/%h", k, buffer_addr, buffer_we, buffer_din, a[k], w[k], {4{d[k]}});
      end
    end
    tick();
    #1;
    checks++;
    if (buffer_en !== 1'b0 || wr_ready !== 1'b1) begin
      failures++; $display("FAIL fifo_full_drained: got en=%b ready=%b expected 0/1", buffer_en, wr_ready);
    end
  endtask

  task automatic test_read_return();
    tick();
    rd_valid = 1'b1; rd_addr = 17'd6;
    #1;
    checks++;
    if (buffer_en !== 1'b1 || buffer_we !== 4'h0 || buffer_addr !== 32'd6) begin
      failures++; $display("FAIL read_return_issue: got en=%b we=%h addr=%h expected 1/0/6", buffer_en, buffer_we, buffer_addr);
    end
    tick();
    rd_valid = 1'b0;
    #1;
    checks++;
    if (rd_byte !== 8'h33 || rd_byte_valid !== 1'b1) begin
      failures++; $display("FAIL read_return_data: got byte=%h valid=%b expected 33/1", rd_byte, rd_byte_valid);
    end
    tick();
    #1;
    checks++;
    if (rd_byte_valid !== 1'b0 || rd_byte !== 8'h00) begin
      failures++; $display("FAIL read_return_idle: got byte=%h valid=%b expected 00/0", rd_byte, rd_byte_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] a [4];
    logic [7:0]  b [4];
    a[0] = 17'h43; b[0] = 8'h44;
    a[1] = 17'h44; b[1] = 8'h11;
    a[2] = 17'h4A; b[2] = 8'h33;
    a[3] = 17'h4D; b[3] = 8'h22;
    for (int c = 0; c < 5; c++) begin
      tick();
      rd_valid = (c < 4);
      if (c < 4) rd_addr = a[c];
      #1;
      if (c > 0) begin
        checks++;
        if (rd_byte !== b[c-1] || rd_byte_valid !== 1'b1) begin
          failures++; $display("FAIL back_to_back_read%0d: got byte=%h valid=%b expected %h/1", c - 1, rd_byte, rd_byte_valid, b[c-1]);
        end
      end
    end
    tick();
    #1;
    checks++;
    if (rd_byte_valid !== 1'b0) begin
      failures++; $display("FAIL back_to_back_tail: got valid=%b expected 0", rd_byte_valid);
    end
  endtask

  task automatic test_clear();
    int          bad;
    int          first_bad;
    int          done_count;
    logic [31:0] last_addr;
    bad = 0; first_bad = -1; done_count = 0; last_addr = '0;
    tick();
    rd_valid = 1'b0; clear_start = 1'b1; clear_color = 8'h1C;
    #1;
    checks++;
    if (clear_busy !== 1'b0 || buffer_en !== 1'b0) begin
      failures++; $display("FAIL clear_start_cycle: got busy=%b en=%b expected 0/0", clear_busy, buffer_en);
    end
    for (int i = 1; i <= 30000; i++) begin
      tick();
      clear_start = (i == 100);
      clear_color = (i == 100) ? 8'hFF : 8'h1C;
      wr_valid    = (i == 200);
      wr_addr     = 17'd7;
      wr_data     = 8'h99;
      #1;
      if (buffer_we !== 4'hF || buffer_en !== 1'b1 || buffer_addr !== 32'(4 * (i - 1)) ||
          buffer_din !== 32'h1C1C1C1C || clear_busy !== 1'b1) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
      if (clear_done === 1'b1) done_count++;
      if (i == 30000) last_addr = buffer_addr;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL clear_words: got %0d bad cycles (first %0d) expected 0", bad, first_bad);
    end
    checks++;
    if (last_addr !== 32'd119996) begin
      failures++; $display("FAIL clear_last_addr: got %0d expected 119996", last_addr);
    end
    tick();
    wr_valid = 1'b0;
    #1;
    if (clear_done === 1'b1) done_count++;
    checks++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0) begin
      failures++; $display("FAIL clear_done_pulse: got done=%b busy=%b expected 1/0", clear_done, clear_busy);
    end
    checks++;
    if (buffer_addr !== 32'd7 || buffer_we !== 4'b1000 || buffer_din !== 32'h99999999) begin
      failures++; $display("FAIL clear_queued_write: got addr=%h we=%b din=%h expected 7/1000/99999999", buffer_addr, buffer_we, buffer_din);
    end
    tick();
    #1;
    if (clear_done === 1'b1) done_count++;
    checks++;
    if (done_count !== 1) begin
      failures++; $display("FAIL clear_done_count: got %0d expected 1", done_count);
    end
    checks++;
    if (buffer_en !== 1'b0) begin
      failures++; $display("FAIL clear_after_idle: got en=%b expected 0", buffer_en);
    end
  endtask

  task automatic test_clear_reads_reset();
    int bad;
    int first_bad;
    int done_count;
    bad = 0; first_bad = -1; done_count = 0;
    tick();
    rd_valid = 1'b0; clear_start = 1'b1; clear_color = 8'h3C;
    #1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      clear_start = 1'b0;
      rd_valid    = (i % 2 == 1);
      rd_addr     = 17'd0;
      wr_valid    = (i == 50);
      wr_addr     = 17'd9;
      wr_data     = 8'h77;
      #1;
      if (i % 2 == 1) begin
        if (buffer_we !== 4'h0 || buffer_en !== 1'b1 || buffer_addr !== 32'd0) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end else begin
        if (buffer_we !== 4'hF || buffer_addr !== 32'(4 * ((i - 2) / 2)) || buffer_din !== 32'h3C3C3C3C) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL clear_with_reads: got %0d bad cycles (first %0d) expected 0", bad, first_bad);
    end
    checks++;
    if (clear_busy !== 1'b1) begin
      failures++; $display("FAIL clear_with_reads_busy: got %b expected 1", clear_busy);
    end
    tick();
    rst = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
    #1;
    checks++;
    if (buffer_we !== 4'h0 || wr_ready !== 1'b0) begin
      failures++; $display("FAIL mid_clear_reset: got we=%h ready=%b expected 0/0", buffer_we, wr_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (clear_busy !== 1'b0) begin
      failures++; $display("FAIL mid_clear_reset_busy: got %b expected 0", clear_busy);
    end
    for (int i = 0; i < 5; i++) begin
      if (clear_done === 1'b1 || buffer_en !== 1'b0) done_count++;
      tick();
      #1;
    end
    checks++;
    if (done_count !== 0) begin
      failures++; $display("FAIL mid_clear_reset_quiet: got %0d active cycles expected 0", done_count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    rd_valid    = 1'b0;
    rd_addr     = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    clear_start = 1'b0;
    clear_color = '0;
    buffer_dout = 32'h44332211;

    test_reset();
    test_idle_write();
    test_read_priority();
    test_fifo_full();
    test_read_return();
    test_back_to_back();
    test_clear();
    test_clear_reads_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
